// File: rtl/bfp_frame_bw_tracker_pkg.sv
// Shared types and helpers for the block-floating-point frame width tracker.
package bfp_frame_bw_tracker_pkg;

    // Widest sample the width helper accepts; callers sign-extend into this.
    localparam int unsigned MaxDw = 64;

    // Wide enough to hold any significant width up to MaxDw.
    typedef logic [6:0] bw_t;

    // Width of a field able to hold the values 0..dw.
    function automatic int unsigned f_bww(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    // Significant two's-complement width: one sign bit plus everything below the
    // highest bit that differs from the sign. The highest differing bit wins.
    function automatic bw_t f_sig_width(input logic [MaxDw-1:0] x);
        bw_t n;
        n = bw_t'(1);
        for (int i = 0; i < int'(MaxDw) - 1; i++) begin
            if (x[i] != x[MaxDw-1]) begin
                n = bw_t'(i + 2);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bfp_frame_bw_tracker_lane_max.sv
// Two-stage front end: per-lane significant width (S1), then max over lanes (S2).
module bfp_frame_bw_tracker_lane_max
    import bfp_frame_bw_tracker_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned BWW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [NCH*DW-1:0] in_data,
    output logic              s2_valid,
    output logic              s2_last,
    output logic [BWW-1:0]    s2_bw
);

    logic [BWW-1:0] lane_bw [NCH];
    logic [BWW-1:0] bw1_q   [NCH];
    logic           v1_q;
    logic           l1_q;
    logic [BWW-1:0] max_bw;
    logic           v2_q;
    logic           l2_q;
    logic [BWW-1:0] bw2_q;

    // Per-lane width of the incoming samples.
    always_comb begin
        for (int k = 0; k < int'(NCH); k++) begin
            lane_bw[k] = BWW'(f_sig_width(MaxDw'($signed(in_data[k*DW +: DW]))));
        end
    end

    // S1: register lane widths; clr squashes the beat entering this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            l1_q <= 1'b0;
            for (int k = 0; k < int'(NCH); k++) begin
                bw1_q[k] <= '0;
            end
        end else begin
            v1_q <= in_valid & ~clr;
            l1_q <= in_valid & in_last & ~clr;
            for (int k = 0; k < int'(NCH); k++) begin
                bw1_q[k] <= lane_bw[k];
            end
        end
    end

    // Reduce the registered lane widths to their maximum.
    always_comb begin
        max_bw = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (bw1_q[k] > max_bw) begin
                max_bw = bw1_q[k];
            end
        end
    end

    // S2: register the beat maximum; clr squashes whatever sits in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            l2_q  <= 1'b0;
            bw2_q <= '0;
        end else begin
            v2_q  <= v1_q & ~clr;
            l2_q  <= l1_q & ~clr;
            bw2_q <= max_bw;
        end
    end

    assign s2_valid = v2_q;
    assign s2_last  = l2_q;
    assign s2_bw    = bw2_q;

endmodule

// File: rtl/bfp_frame_bw_tracker.sv
// Frame maximum-width tracker: accumulates the per-beat max and commits the frame
// maximum plus normalisation shift into a held, acknowledged result.
module bfp_frame_bw_tracker
    import bfp_frame_bw_tracker_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned NCH       = 4,
    parameter int unsigned TARGET_BW = DW - 2,
    localparam int unsigned BWW      = f_bww(DW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [NCH*DW-1:0] in_data,
    output logic [BWW-1:0]    running_bw,
    output logic              res_valid,
    input  logic              res_ack,
    output logic [BWW-1:0]    res_max_bw,
    output logic [BWW-1:0]    res_shift,
    output logic              res_overrun
);

    localparam logic [BWW-1:0] TargetBw = BWW'(TARGET_BW);

    logic           s2_valid;
    logic           s2_last;
    logic [BWW-1:0] s2_bw;

    logic [BWW-1:0] acc_q, acc_d;
    logic [BWW-1:0] cand;
    logic [BWW-1:0] cand_shift;
    logic           commit;
    logic           res_valid_q, res_valid_d;
    logic [BWW-1:0] res_max_q, res_max_d;
    logic [BWW-1:0] res_shift_q, res_shift_d;
    logic           res_overrun_q, res_overrun_d;

    bfp_frame_bw_tracker_lane_max #(
        .DW  (DW),
        .NCH (NCH),
        .BWW (BWW)
    ) u_lane_max (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_data  (in_data),
        .s2_valid (s2_valid),
        .s2_last  (s2_last),
        .s2_bw    (s2_bw)
    );

    // Accumulator and result next-state; clr discards a commit arriving on its edge.
    always_comb begin
        cand          = (s2_bw > acc_q) ? s2_bw : acc_q;
        cand_shift    = (cand > TargetBw) ? cand - TargetBw : '0;
        commit        = s2_valid & s2_last & ~clr;
        acc_d         = acc_q;
        res_valid_d   = res_valid_q;
        res_max_d     = res_max_q;
        res_shift_d   = res_shift_q;
        res_overrun_d = res_overrun_q;

        if (clr || commit) begin
            acc_d = '0;
        end else if (s2_valid) begin
            acc_d = cand;
        end

        if (commit) begin
            res_valid_d = 1'b1;
            res_max_d   = cand;
            res_shift_d = cand_shift;
            // Overwriting a result nobody has taken yet.
            if (res_valid_q && !res_ack) begin
                res_overrun_d = 1'b1;
            end
        end else if (res_valid_q && res_ack) begin
            res_valid_d = 1'b0;
        end
    end

    // Accumulator and held-result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q         <= '0;
            res_valid_q   <= 1'b0;
            res_max_q     <= '0;
            res_shift_q   <= '0;
            res_overrun_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            res_valid_q   <= res_valid_d;
            res_max_q     <= res_max_d;
            res_shift_q   <= res_shift_d;
            res_overrun_q <= res_overrun_d;
        end
    end

    assign running_bw  = acc_q;
    assign res_valid   = res_valid_q;
    assign res_max_bw  = res_max_q;
    assign res_shift   = res_shift_q;
    assign res_overrun = res_overrun_q;

endmodule
